// File: rtl/seq_div8.sv
// seq_div8: sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV8_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up and ovf).
module seq_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [2*WIDTH:0] aq_shift;
  logic [WIDTH:0]   a_shift, a_next;
  logic [WIDTH-1:0] q_shift, q_next;
  logic [WIDTH-1:0] load_dividend, load_divisor;
  logic [WIDTH-1:0] final_quotient, final_remainder;

`ifdef DIV8_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic ovf_pend_q, ovf_pend_d;
  logic ovf_q, ovf_d;
`endif

  // One restoring step: shift {A,Q} left, keep A-D only when it does not go negative.
  always_comb begin
    aq_shift = {a_q, q_q} << 1;
    a_shift  = aq_shift[2*WIDTH:WIDTH];
    q_shift  = aq_shift[WIDTH-1:0];
    if (a_shift >= {1'b0, d_q}) begin
      a_next = a_shift - {1'b0, d_q};
      q_next = q_shift | WIDTH'(1);
    end else begin
      a_next = a_shift;
      q_next = q_shift;
    end
  end

  always_comb begin
`ifdef DIV8_SIGNED_EN
    load_dividend   = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    load_divisor    = divisor[WIDTH-1] ? ('0 - divisor) : divisor;
    final_quotient  = neg_quot_q ? ('0 - q_next) : q_next;
    final_remainder = neg_rem_q ? ('0 - a_next[WIDTH-1:0]) : a_next[WIDTH-1:0];
`else
    load_dividend   = dividend;
    load_divisor    = divisor;
    final_quotient  = q_next;
    final_remainder = a_next[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dz_d        = dz_q;
`ifdef DIV8_SIGNED_EN
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    ovf_pend_d  = ovf_pend_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            a_d     = '0;
            q_d     = load_dividend;
            d_d     = load_divisor;
            cnt_d   = CNT_LAST;
            busy_d  = 1'b1;
`ifdef DIV8_SIGNED_EN
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
            ovf_pend_d = (dividend == MIN_NEG) && (divisor == '1);
`endif
          end else begin
            // Divide by zero skips the core and reports straight away.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dz_d        = 1'b1;
            done_d      = 1'b1;
`ifdef DIV8_SIGNED_EN
            ovf_d       = 1'b0;
`endif
          end
        end
      end
      RUN: begin
        a_d = a_next;
        q_d = q_next;
        if (cnt_q == '0) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = final_quotient;
          remainder_d = final_remainder;
          dz_d        = 1'b0;
`ifdef DIV8_SIGNED_EN
          ovf_d       = ovf_pend_q;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
`ifdef DIV8_SIGNED_EN
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
`ifdef DIV8_SIGNED_EN
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      ovf_pend_q  <= ovf_pend_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dz        = dz_q;
`ifdef DIV8_SIGNED_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: self-checking bench for seq_div8 against a plain-arithmetic reference model.
// Signed-mode vectors are exercised when DIV8_SIGNED_EN is defined.
module tb_seq_div8;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor;
  logic [7:0] quotient, remainder;
  logic       busy, done, dz, ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_div8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
  );

  // Reference: results straight from integer division rules.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dzv, output logic ovfv);
    int sa, sb;
    dzv = 1'b0;
    ovfv = 1'b0;
    sa = 0;
    sb = 0;
    if (b == 8'h00) begin
      q = 8'hFF; r = a; dzv = 1'b1;
    end
`ifdef DIV8_SIGNED_EN
    else if (a == 8'h80 && b == 8'hFF) begin
      q = 8'h80; r = 8'h00; ovfv = 1'b1;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end
`else
    else begin
      q = a / b; r = a % b;
    end
`endif
  endfunction

  // Runs one operation; returns outputs sampled in the done cycle, edges from the accepting edge
  // to the done cycle (accepting edge counts as 1), and how many cycles busy was seen high.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dzv, output logic ovfv,
                       output int edges, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    edges = 1;
    busy_cyc = 0;
    while (1) begin
      @(negedge clk);
      if (done === 1'b1 || edges >= 20) break;
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk);
      edges++;
    end
    q = quotient; r = remainder; dzv = dz; ovfv = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    repeat (2) @(negedge clk);
    vectors++; if (quotient !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_quotient got %h exp 00", quotient); end
    vectors++; if (remainder !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_remainder got %h exp 00", remainder); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b exp 0", done); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dz got %b exp 0", dz); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf got %b exp 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] q, r, eq, er;
    logic dzv, ovfv, edz, eovf;
    int edges, bc;
    ref_div(8'd200, 8'd7, eq, er, edz, eovf);
    do_op(8'd200, 8'd7, q, r, dzv, ovfv, edges, bc);
    vectors++; if (q !== eq) begin miscompares++; $display("[TB] FAIL basic_quotient got %h exp %h", q, eq); end
    vectors++; if (r !== er) begin miscompares++; $display("[TB] FAIL basic_remainder got %h exp %h", r, er); end
    vectors++; if (dzv !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_dz got %b exp 0", dzv); end
    vectors++; if (edges != 9) begin miscompares++; $display("[TB] FAIL basic_latency got %0d exp 9", edges); end
    vectors++; if (bc != 8) begin miscompares++; $display("[TB] FAIL basic_busy_cycles got %0d exp 8", bc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy_at_done got %b exp 0", busy); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done_pulse got %b exp 0", done); end
    vectors++; if (quotient !== eq) begin miscompares++; $display("[TB] FAIL basic_hold got %h exp %h", quotient, eq); end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r, eq, er;
    logic dzv, ovfv, edz, eovf;
    int edges, bc;
    do_op(8'd5, 8'd0, q, r, dzv, ovfv, edges, bc);
    vectors++; if (q !== 8'hFF) begin miscompares++; $display("[TB] FAIL dz_quotient got %h exp ff", q); end
    vectors++; if (r !== 8'h05) begin miscompares++; $display("[TB] FAIL dz_remainder got %h exp 05", r); end
    vectors++; if (dzv !== 1'b1) begin miscompares++; $display("[TB] FAIL dz_flag got %b exp 1", dzv); end
    vectors++; if (ovfv !== 1'b0) begin miscompares++; $display("[TB] FAIL dz_ovf got %b exp 0", ovfv); end
    vectors++; if (edges != 1) begin miscompares++; $display("[TB] FAIL dz_latency got %0d exp 1", edges); end
    ref_div(8'd9, 8'd3, eq, er, edz, eovf);
    do_op(8'd9, 8'd3, q, r, dzv, ovfv, edges, bc);
    vectors++; if (dzv !== 1'b0) begin miscompares++; $display("[TB] FAIL dz_clear got %b exp 0", dzv); end
    vectors++; if (q !== eq) begin miscompares++; $display("[TB] FAIL dz_next_quotient got %h exp %h", q, eq); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] eq1, er1, eq2, er2;
    logic ed, eo;
    int edges, gap;
    ref_div(8'd255, 8'd1, eq1, er1, ed, eo);
    ref_div(8'd7, 8'd9, eq2, er2, ed, eo);
    @(negedge clk);
    start = 1'b1; dividend = 8'd255; divisor = 8'd1;
    @(posedge clk);
    #1;
    dividend = 8'd7; divisor = 8'd9;
    edges = 1;
    while (1) begin
      @(negedge clk);
      if (done === 1'b1 || edges >= 20) break;
      @(posedge clk);
      edges++;
    end
    vectors++; if (edges != 9) begin miscompares++; $display("[TB] FAIL b2b_first_latency got %0d exp 9", edges); end
    vectors++; if (quotient !== eq1) begin miscompares++; $display("[TB] FAIL b2b_first_quotient got %h exp %h", quotient, eq1); end
    vectors++; if (remainder !== er1) begin miscompares++; $display("[TB] FAIL b2b_first_remainder got %h exp %h", remainder, er1); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_gap got busy=%b done=%b exp 0 0", busy, done); end
    gap = 0;
    while (1) begin
      @(posedge clk);
      gap++;
      @(negedge clk);
      if (gap == 4) begin
        vectors++; if (quotient !== eq1) begin miscompares++; $display("[TB] FAIL b2b_hold_in_run got %h exp %h", quotient, eq1); end
      end
      if (done === 1'b1 || gap >= 20) break;
    end
    start = 1'b0;
    vectors++; if (gap != 9) begin miscompares++; $display("[TB] FAIL b2b_second_latency got %0d exp 9", gap); end
    vectors++; if (quotient !== eq2) begin miscompares++; $display("[TB] FAIL b2b_second_quotient got %h exp %h", quotient, eq2); end
    vectors++; if (remainder !== er2) begin miscompares++; $display("[TB] FAIL b2b_second_remainder got %h exp %h", remainder, er2); end
  endtask

  task automatic test_ignore_start();
    logic [7:0] q, r, eq0, er0, eq, er;
    logic dzv, ovfv, ed, eo;
    int edges, bc;
    ref_div(8'd50, 8'd6, eq0, er0, ed, eo);
    do_op(8'd50, 8'd6, q, r, dzv, ovfv, edges, bc);
    ref_div(8'd200, 8'd7, eq, er, ed, eo);
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (1) begin
      @(negedge clk);
      if (done === 1'b1 || edges >= 20) break;
      if (edges == 3) begin
        vectors++; if (quotient !== eq0) begin miscompares++; $display("[TB] FAIL ignore_hold got %h exp %h", quotient, eq0); end
        start = 1'b1; dividend = 8'd33; divisor = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
    vectors++; if (edges != 9) begin miscompares++; $display("[TB] FAIL ignore_latency got %0d exp 9", edges); end
    vectors++; if (quotient !== eq) begin miscompares++; $display("[TB] FAIL ignore_quotient got %h exp %h", quotient, eq); end
    vectors++; if (remainder !== er) begin miscompares++; $display("[TB] FAIL ignore_remainder got %h exp %h", remainder, er); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_no_queue got busy=%b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    logic [7:0] q, r;
    logic dzv, ovfv;
    int edges, bc;
    @(negedge clk);
    start = 1'b1; dividend = 8'd123; divisor = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (quotient !== 8'h00) begin miscompares++; $display("[TB] FAIL arst_quotient got %h exp 00", quotient); end
    vectors++; if (remainder !== 8'h00) begin miscompares++; $display("[TB] FAIL arst_remainder got %h exp 00", remainder); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0 || dz !== 1'b0 || ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_flags got done=%b dz=%b ovf=%b exp 0 0 0", done, dz, ovf); end
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd100, 8'd10, q, r, dzv, ovfv, edges, bc);
    vectors++; if (q !== 8'd10) begin miscompares++; $display("[TB] FAIL arst_after_quotient got %h exp 0a", q); end
    vectors++; if (r !== 8'd0) begin miscompares++; $display("[TB] FAIL arst_after_remainder got %h exp 00", r); end
    vectors++; if (edges != 9) begin miscompares++; $display("[TB] FAIL arst_after_latency got %0d exp 9", edges); end
  endtask

`ifdef DIV8_SIGNED_EN
  task automatic test_signed();
    logic [7:0] q, r;
    logic dzv, ovfv;
    int edges, bc;
    do_op(8'h9C, 8'd7, q, r, dzv, ovfv, edges, bc);
    vectors++; if (q !== 8'hF2 || r !== 8'hFE) begin miscompares++; $display("[TB] FAIL signed_m100_7 got q=%h r=%h exp f2 fe", q, r); end
    vectors++; if (edges != 9) begin miscompares++; $display("[TB] FAIL signed_latency got %0d exp 9", edges); end
    do_op(8'h80, 8'hFF, q, r, dzv, ovfv, edges, bc);
    vectors++; if (q !== 8'h80 || r !== 8'h00) begin miscompares++; $display("[TB] FAIL signed_ovf_result got q=%h r=%h exp 80 00", q, r); end
    vectors++; if (ovfv !== 1'b1) begin miscompares++; $display("[TB] FAIL signed_ovf_flag got %b exp 1", ovfv); end
    do_op(8'd100, 8'hF9, q, r, dzv, ovfv, edges, bc);
    vectors++; if (q !== 8'hF2 || r !== 8'h02) begin miscompares++; $display("[TB] FAIL signed_100_m7 got q=%h r=%h exp f2 02", q, r); end
    vectors++; if (ovfv !== 1'b0) begin miscompares++; $display("[TB] FAIL signed_ovf_clear got %b exp 0", ovfv); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] a, b, q, r, eq, er;
    logic dzv, ovfv, edz, eovf;
    int edges, bc;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom);
      if (i % 8 == 0) b = 8'h00;
      else if (i % 3 == 0) b = 8'($urandom_range(1, 15));
      else b = 8'($urandom);
      if (i == 1) begin a = 8'h80; b = 8'hFF; end
      ref_div(a, b, eq, er, edz, eovf);
      do_op(a, b, q, r, dzv, ovfv, edges, bc);
      vectors++; if (q !== eq) begin miscompares++; $display("[TB] FAIL rand_quotient %h/%h got %h exp %h", a, b, q, eq); end
      vectors++; if (r !== er) begin miscompares++; $display("[TB] FAIL rand_remainder %h/%h got %h exp %h", a, b, r, er); end
      vectors++; if (dzv !== edz) begin miscompares++; $display("[TB] FAIL rand_dz %h/%h got %b exp %b", a, b, dzv, edz); end
      vectors++; if (ovfv !== eovf) begin miscompares++; $display("[TB] FAIL rand_ovf %h/%h got %b exp %b", a, b, ovfv, eovf); end
      vectors++; if (edges != ((b == 8'h00) ? 1 : 9)) begin miscompares++; $display("[TB] FAIL rand_latency %h/%h got %0d exp %0d", a, b, edges, (b == 8'h00) ? 1 : 9); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
`ifdef DIV8_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
